spmv_vec_prefetch: RTL

Dense-vector prefetch engine for the SpMV accelerator, directly downstream of the tight accelerator command interface. On a start pulse carrying the vector pointer and length, it fetches every 64 B cache line covering the vector through the DCP memory request/response interface and stores the lines in a local buffer. It then signals completion so the compute stage can begin. The compute channels read elements back by index through a single 1-cycle read port.

---
 rtl/spmv_pkg.sv | 31 +++
 rtl/spmv_vec_buf.sv | 55 +++++
 rtl/spmv_vec_prefetch.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/spmv_pkg.sv
// Shared definitions for the SpMV dense-vector prefetch engine:
// line/element geometry, prefetch FSM states, transid layout, line-count helper.
package spmv_pkg;

    localparam int LINE_BYTES = 64;
    localparam int ELEM_BYTES = 4;
    localparam int LINE_SHIFT = $clog2(LINE_BYTES);
    localparam int WORDS_PER_LINE = LINE_BYTES / ELEM_BYTES;

    // transid = {epoch, line index}
    localparam int TID_W = 6;
    localparam int TID_EPOCH = 5;
    localparam int TID_IDX_W = 5;

    typedef enum logic [1:0] {
        PF_IDLE,
        PF_ISSUE,
        PF_DRAIN,
        PF_DONE
    } pf_state_e;

    // Number of 64 B lines touched by len 32-bit elements starting at
    // byte offset off within the first line.
    function automatic logic [21:0] calc_nlines(input logic [5:0] off,
                                                input logic [15:0] len);
        logic [21:0] total;
        total = 22'(off) + 22'(len) * 22'(ELEM_BYTES);
        return (total + 22'(LINE_BYTES - 1)) / 22'(LINE_BYTES);
    endfunction

endpackage

// File: rtl/spmv_vec_buf.sv
// Line buffer for the prefetched dense vector.
// Ports: clk/rst; clr clears all line-valid bits; wr_en/wr_line/wr_data write
// one full line and mark it valid; valid is the per-line valid vector;
// rd_line/rd_word select a 32-bit element, returned on rd_data one cycle later.
module spmv_vec_buf
    import spmv_pkg::*;
#(
    parameter int LINE_W = 512,
    parameter int MAX_LINES = 16,
    localparam int IW = (MAX_LINES > 1) ? $clog2(MAX_LINES) : 1,
    localparam int WW = $clog2(WORDS_PER_LINE)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clr,
    input  logic                 wr_en,
    input  logic [IW-1:0]        wr_line,
    input  logic [LINE_W-1:0]    wr_data,
    output logic [MAX_LINES-1:0] valid,
    input  logic [TID_IDX_W-1:0] rd_line,
    input  logic [WW-1:0]        rd_word,
    output logic [31:0]          rd_data
);

    logic [LINE_W-1:0] mem [MAX_LINES];
    logic [WW+4:0]     bit_off;

    assign bit_off = {rd_word, 5'd0};

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_line] <= wr_data;
        end
    end

    // clear wins over a same-cycle write so a new run starts empty
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            valid <= '0;
        end else if (wr_en) begin
            valid[wr_line] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data <= '0;
        end else if (32'(rd_line) < MAX_LINES) begin
            rd_data <= mem[rd_line[IW-1:0]][bit_off +: 32];
        end else begin
            rd_data <= '0;
        end
    end

endmodule

// File: rtl/spmv_vec_prefetch.sv
// Dense-vector prefetch engine: fetches every 64 B line covering a vector
// into a local buffer, pulses done, then serves element reads by index.
// Ports: start/vec_pntr/vec_len command; busy/done/err status;
// mem_req_* request channel (val/rdy); mem_resp_* response channel;
// buf_rd_idx/buf_rd_data registered element read port.
module spmv_vec_prefetch
    import spmv_pkg::*;
#(
    parameter int PADDR_W = 40,
    parameter int LINE_W = 512,
    parameter int MAX_LINES = 16,
    parameter int MAX_OUTSTANDING = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [PADDR_W-1:0] vec_pntr,
    input  logic [15:0]        vec_len,
    output logic               busy,
    output logic               done,
    output logic               err,
    input  logic               mem_req_rdy,
    output logic               mem_req_val,
    output logic [TID_W-1:0]   mem_req_transid,
    output logic [PADDR_W-1:0] mem_req_addr,
    input  logic               mem_resp_val,
    input  logic [TID_W-1:0]   mem_resp_transid,
    input  logic [LINE_W-1:0]  mem_resp_data,
    input  logic [15:0]        buf_rd_idx,
    output logic [31:0]        buf_rd_data
);

    localparam int IW = (MAX_LINES > 1) ? $clog2(MAX_LINES) : 1;
    localparam int OW = $clog2(MAX_OUTSTANDING + 1);

    pf_state_e state_q, state_d;

    logic [PADDR_W-1:0]   base_q;
    logic [5:0]           off_q;
    logic [21:0]          nlines_q;
    logic                 epoch_q;
    logic                 err_q;
    logic [5:0]           issue_ptr_q;
    logic [OW-1:0]        outst_q;

    logic [5:0]           off_new;
    logic [21:0]          nlines_new;
    logic                 too_big;
    logic                 start_acc;
    logic                 req_hs;
    logic                 resp_acc;
    logic [TID_IDX_W-1:0] resp_idx;
    logic [21:0]          ptr_ext;
    logic                 issue_fin;
    logic [MAX_LINES-1:0] line_valid;
    logic [MAX_LINES-1:0] need_mask;
    logic [MAX_LINES-1:0] valid_nx;
    logic                 all_valid_nx;
    logic [17:0]          rd_byte;
    logic                 unused_rd;

    assign off_new    = {vec_pntr[5:2], 2'b00};
    assign nlines_new = calc_nlines(off_new, vec_len);
    assign too_big    = nlines_new > 22'(MAX_LINES);
    assign start_acc  = start && (state_q == PF_IDLE);
    assign ptr_ext    = 22'(issue_ptr_q);
    assign req_hs     = mem_req_val && mem_req_rdy;
    assign resp_idx   = mem_resp_transid[TID_IDX_W-1:0];

    // Stale epochs, out-of-range indices and duplicates are dropped.
    assign resp_acc = mem_resp_val
                   && (mem_resp_transid[TID_EPOCH] == epoch_q)
                   && (22'(resp_idx) < nlines_q)
                   && (32'(resp_idx) < MAX_LINES)
                   && !line_valid[resp_idx[IW-1:0]];

    // Completion looks at this cycle's accepted response too, so done
    // follows the last response by one cycle.
    always_comb begin
        valid_nx = line_valid;
        if (resp_acc) begin
            valid_nx[resp_idx[IW-1:0]] = 1'b1;
        end
        for (int i = 0; i < MAX_LINES; i++) begin
            need_mask[i] = 22'(i) < nlines_q;
        end
        all_valid_nx = &(valid_nx | ~need_mask);
    end

    assign issue_fin = (ptr_ext == nlines_q)
                    || (req_hs && (ptr_ext + 22'd1 == nlines_q));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= PF_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            PF_IDLE: begin
                if (start_acc) begin
                    if (vec_len == 16'd0 || too_big) begin
                        state_d = PF_DONE;
                    end else begin
                        state_d = PF_ISSUE;
                    end
                end
            end
            PF_ISSUE: begin
                if (issue_fin) begin
                    state_d = all_valid_nx ? PF_DONE : PF_DRAIN;
                end
            end
            PF_DRAIN: begin
                if (all_valid_nx) begin
                    state_d = PF_DONE;
                end
            end
            PF_DONE: state_d = PF_IDLE;
            default: state_d = PF_IDLE;
        endcase
    end

    always_comb begin
        busy        = state_q != PF_IDLE;
        done        = state_q == PF_DONE;
        mem_req_val = (state_q == PF_ISSUE)
                   && (ptr_ext < nlines_q)
                   && (outst_q < OW'(MAX_OUTSTANDING));
    end

    // Address/transid derive only from registers that move on a handshake,
    // so they stay stable under backpressure.
    assign mem_req_addr    = base_q + (PADDR_W'(issue_ptr_q) << LINE_SHIFT);
    assign mem_req_transid = {epoch_q, issue_ptr_q[TID_IDX_W-1:0]};
    assign err             = err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            base_q      <= '0;
            off_q       <= '0;
            nlines_q    <= '0;
            epoch_q     <= 1'b0;
            err_q       <= 1'b0;
            issue_ptr_q <= '0;
            outst_q     <= '0;
        end else if (start_acc) begin
            base_q      <= vec_pntr & ~PADDR_W'(LINE_BYTES - 1);
            off_q       <= off_new;
            nlines_q    <= nlines_new;
            epoch_q     <= ~epoch_q;
            err_q       <= too_big;
            issue_ptr_q <= '0;
            outst_q     <= '0;
        end else begin
            if (req_hs) begin
                issue_ptr_q <= issue_ptr_q + 6'd1;
            end
            if (req_hs && !resp_acc) begin
                outst_q <= outst_q + OW'(1);
            end else if (!req_hs && resp_acc && outst_q != '0) begin
                outst_q <= outst_q - OW'(1);
            end
        end
    end

    assign rd_byte   = 18'(off_q) + {buf_rd_idx, 2'b00};
    assign unused_rd = ^{rd_byte[17:11], rd_byte[1:0]};

    spmv_vec_buf #(
        .LINE_W    (LINE_W),
        .MAX_LINES (MAX_LINES)
    ) u_buf (
        .clk     (clk),
        .rst     (rst),
        .clr     (start_acc),
        .wr_en   (resp_acc),
        .wr_line (resp_idx[IW-1:0]),
        .wr_data (mem_resp_data),
        .valid   (line_valid),
        .rd_line (rd_byte[10:6]),
        .rd_word (rd_byte[5:2]),
        .rd_data (buf_rd_data)
    );

endmodule
